// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared elaboration helpers for the pipelined ALU adder.
//                slice_width() gives the bits handled per pipeline stage;
//                stages_ok() validates the WIDTH/STAGES pairing.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Bits per ripple slice. Guarded against STAGES = 0 so a bad parameter
    // reaches the friendly elaboration error instead of a divide-by-zero.
    function automatic int slice_width(input int width, input int stages);
        return (stages > 0) ? (width / stages) : width;
    endfunction

    // Legal when 1 <= stages <= width and stages divides width.
    function automatic bit stages_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder_slice.sv
`default_nettype none
// ============================================================================
//  Module      : adder_slice
//  Description : Combinational N-bit ripple slice of the pipelined adder.
//  Ports       : a, b      - slice operands (b already conditioned for sub)
//                cin       - carry into bit 0 of the slice
//                s         - slice sum
//                cout      - carry out of the slice's top bit
//                c_msb_in  - carry into the slice's top bit (overflow term)
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_slice #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         c_msb_in
);

    logic [N:0] w_full;

    assign w_full = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    assign s      = w_full[N-1:0];
    assign cout   = w_full[N];

    // Each sum bit is a ^ b ^ carry-in, so the carry into the top bit is
    // recovered by XOR-ing the top sum bit back out.
    assign c_msb_in = a[N-1] ^ b[N-1] ^ w_full[N-1];

endmodule
`default_nettype wire

// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_adder
//  Description : WIDTH-bit add/subtract built from STAGES ripple slices with
//                registered inter-slice carries. Valid/ready on both sides,
//                one op per cycle, backpressure-safe, results in order.
//  Ports       : clk, rst            - clock, async active-high reset
//                in_valid/in_ready   - operand handshake
//                a, b, carry_in, sub - operands; sub=1 computes a - b
//                out_valid/out_ready - result handshake
//                sum, carry_out,     - result and flags (carry_out is the
//                overflow, zero        not-borrow flag when subtracting)
//  Revision    : 1.0 - initial release
// ============================================================================
module pipelined_adder
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int SLICE = slice_width(WIDTH, STAGES);

    if (!stages_ok(WIDTH, STAGES)) begin : g_param_check
        $error("pipelined_adder: STAGES=%0d must divide WIDTH=%0d", STAGES, WIDTH);
    end

    logic [WIDTH-1:0]  w_b_eff;
    logic              w_c0;
    logic [STAGES-1:0] w_v;
    logic [STAGES-1:0] w_adv;

    // Subtraction as a + ~b + 1; carry_in has no meaning in that mode.
    assign w_b_eff = sub ? ~b : b;
    assign w_c0    = sub | carry_in;

    // A stage may take new contents when it is empty or its successor is
    // moving on, so bubbles are squeezed out under backpressure.
    always_comb begin
        w_adv = '0;
        w_adv[STAGES-1] = !w_v[STAGES-1] || out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            w_adv[k] = !w_v[k] || w_adv[k+1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still to be added on entry to this stage, including
        // the slice this stage computes.
        localparam int REM = WIDTH - k * SLICE;

        logic                   w_vin;
        logic                   w_cin;
        logic                   w_zin;
        logic [REM-1:0]         w_a_in;
        logic [REM-1:0]         w_b_in;
        logic [SLICE-1:0]       w_s;
        logic                   w_cout;
        logic                   w_cmsb;
        logic [(k+1)*SLICE-1:0] w_res_next;

        logic                   r_v;
        logic                   r_c;
        logic                   r_z;   // every result bit completed so far is 0
        logic [(k+1)*SLICE-1:0] r_res;

        if (k == 0) begin : g_src
            assign w_vin      = in_valid;
            assign w_cin      = w_c0;
            assign w_zin      = 1'b1;
            assign w_a_in     = a;
            assign w_b_in     = w_b_eff;
            assign w_res_next = w_s;
        end else begin : g_src
            assign w_vin      = g_stage[k-1].r_v;
            assign w_cin      = g_stage[k-1].r_c;
            assign w_zin      = g_stage[k-1].r_z;
            assign w_a_in     = g_stage[k-1].g_skew.r_a;
            assign w_b_in     = g_stage[k-1].g_skew.r_b;
            assign w_res_next = {w_s, g_stage[k-1].r_res};
        end

        adder_slice #(
            .N (SLICE)
        ) u_slice (
            .a        (w_a_in[SLICE-1:0]),
            .b        (w_b_in[SLICE-1:0]),
            .cin      (w_cin),
            .s        (w_s),
            .cout     (w_cout),
            .c_msb_in (w_cmsb)
        );

        assign w_v[k] = r_v;

        // Data registers only load on a real op; a bubble moving in just
        // clears the valid bit.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_v   <= 1'b0;
                r_c   <= 1'b0;
                r_z   <= 1'b0;
                r_res <= '0;
            end else if (w_adv[k]) begin
                r_v <= w_vin;
                if (w_vin) begin
                    r_c   <= w_cout;
                    r_z   <= w_zin && (w_s == '0);
                    r_res <= w_res_next;
                end
            end
        end

        if (k == STAGES - 1) begin : g_last
            logic r_ovf;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ovf <= 1'b0;
                end else if (w_adv[k] && w_vin) begin
                    r_ovf <= w_cmsb ^ w_cout;
                end
            end
        end else begin : g_skew
            // Upper operand slices wait here until their stage comes up.
            logic [REM-SLICE-1:0] r_a;
            logic [REM-SLICE-1:0] r_b;
            logic                 w_unused_cmsb;

            // Only the top slice's carry-into-MSB matters for overflow.
            assign w_unused_cmsb = w_cmsb;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv[k] && w_vin) begin
                    r_a <= w_a_in[REM-1:SLICE];
                    r_b <= w_b_in[REM-1:SLICE];
                end
            end
        end
    end

    assign in_ready  = w_adv[0];
    assign out_valid = w_v[STAGES-1];
    assign sum       = g_stage[STAGES-1].r_res;
    assign carry_out = g_stage[STAGES-1].r_c;
    assign zero      = g_stage[STAGES-1].r_z;
    assign overflow  = g_stage[STAGES-1].g_last.r_ovf;

`ifdef FORMAL
    // Shadow FIFO of reference {carry, sum} captured at acceptance.
    logic [WIDTH:0] f_ref [STAGES];
    int             f_wr;
    int             f_rd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_wr <= 0;
            f_rd <= 0;
        end else begin
            if (in_valid && in_ready) begin
                f_ref[f_wr] <= {1'b0, a} + {1'b0, w_b_eff} + (WIDTH+1)'(w_c0);
                f_wr        <= (f_wr + 1) % STAGES;
            end
            if (out_valid && out_ready) begin
                f_rd <= (f_rd + 1) % STAGES;
            end
        end
    end

    always_comb begin
        if (!rst && out_valid) begin
            assert ({carry_out, sum} == f_ref[f_rd]);
        end
    end

    a_hold_stable: assert property (@(posedge clk) disable iff (rst)
        out_valid && !out_ready |=> out_valid && $stable({sum, carry_out, overflow, zero}));
`endif

endmodule
`default_nettype wire
